input_conditioner: RTL and testbench

- Front-end stage that feeds the lab top level: conditions the raw board switches and push-buttons before they reach the n-bit registers, counter and barrel-shifter datapath.
- Each input gets a two-flop synchronizer and then a debouncer.
- Outputs are clean switch levels, button levels, and single-cycle press/release strobes.
- Downstream uses the strobes for register enables and resets, and the switch levels for the data inputs.

---
 rtl/input_cond_pkg.sv | 15 +
 rtl/debounce_fsm.sv | 170 +++++++++++++++++
 rtl/input_conditioner.sv | 96 +++++++++
 tb/tb_input_conditioner.sv | 146 ++++++++++++++
 4 files changed

// File: rtl/input_cond_pkg.sv
// Shared definitions for the input conditioner: button FSM state encoding
// and default debounce timing constants.
package input_cond_pkg;

  typedef enum logic [1:0] {
    IDLE_LOW  = 2'd0,
    WAIT_HIGH = 2'd1,
    IDLE_HIGH = 2'd2,
    WAIT_LOW  = 2'd3
  } btn_state_e;

  localparam int DEBOUNCE_CYCLES_DEF = 1000000;
  localparam int CNT_WIDTH_DEF       = 20;

endpackage

// File: rtl/debounce_fsm.sv
// Single-bit conditioner: two-flop synchronizer, debounce counter and FSM.
// Optional auto-repeat of the press strobe when BTN_AUTOREPEAT_EN is defined.
module debounce_fsm
  import input_cond_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int CNT_WIDTH       = CNT_WIDTH_DEF
`ifdef BTN_AUTOREPEAT_EN
  ,
  parameter int REPEAT_DELAY    = 50000000,
  parameter int REPEAT_PERIOD   = 10000000
`endif
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic level,
  output logic press,
  output logic rel
);

  logic                 meta_r;
  logic                 sync_r;
  btn_state_e           state_r;
  btn_state_e           state_nxt_s;
  logic [CNT_WIDTH-1:0] cnt_r;
  logic [CNT_WIDTH-1:0] cnt_nxt_s;
  logic                 level_r;
  logic                 press_r;
  logic                 rel_r;
  logic                 level_nxt_s;
  logic                 press_nxt_s;
  logic                 rel_nxt_s;
  logic                 cnt_last_s;

  // The sample that brings the count to DEBOUNCE_CYCLES-1 is the last stable one needed.
  assign cnt_last_s = (cnt_r == CNT_WIDTH'(DEBOUNCE_CYCLES - 2));

`ifdef BTN_AUTOREPEAT_EN
  logic [31:0] rep_cnt_r;
  logic        rep_first_r;
  logic        rep_fire_s;

  assign rep_fire_s = (state_r == IDLE_HIGH) && sync_r &&
                      (rep_first_r ? (rep_cnt_r == 32'(REPEAT_DELAY - 1))
                                   : (rep_cnt_r == 32'(REPEAT_PERIOD - 1)));

  // Repeat timer: runs only while held in IDLE_HIGH, cleared on any other state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rep_cnt_r   <= 32'd0;
      rep_first_r <= 1'b1;
    end else if (state_r != IDLE_HIGH) begin
      rep_cnt_r   <= 32'd0;
      rep_first_r <= 1'b1;
    end else if (rep_fire_s) begin
      rep_cnt_r   <= 32'd0;
      rep_first_r <= 1'b0;
    end else begin
      rep_cnt_r   <= rep_cnt_r + 32'd1;
    end
  end
`endif

  // State register, synchronizer, counter and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_r  <= 1'b0;
      sync_r  <= 1'b0;
      state_r <= IDLE_LOW;
      cnt_r   <= {CNT_WIDTH{1'b0}};
      level_r <= 1'b0;
      press_r <= 1'b0;
      rel_r   <= 1'b0;
    end else begin
      meta_r  <= raw;
      sync_r  <= meta_r;
      state_r <= state_nxt_s;
      cnt_r   <= cnt_nxt_s;
      level_r <= level_nxt_s;
      press_r <= press_nxt_s;
      rel_r   <= rel_nxt_s;
    end
  end

  // Next-state and counter logic; the counter freezes once a change is accepted.
  always_comb begin
    state_nxt_s = state_r;
    cnt_nxt_s   = cnt_r;
    case (state_r)
      IDLE_LOW: begin
        if (sync_r) begin
          state_nxt_s = WAIT_HIGH;
          cnt_nxt_s   = {CNT_WIDTH{1'b0}};
        end else begin
          state_nxt_s = IDLE_LOW;
        end
      end
      WAIT_HIGH: begin
        if (!sync_r) begin
          state_nxt_s = IDLE_LOW;
        end else if (cnt_last_s) begin
          state_nxt_s = IDLE_HIGH;
          cnt_nxt_s   = cnt_r + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
        end else begin
          cnt_nxt_s   = cnt_r + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
        end
      end
      IDLE_HIGH: begin
        if (!sync_r) begin
          state_nxt_s = WAIT_LOW;
          cnt_nxt_s   = {CNT_WIDTH{1'b0}};
        end else begin
          state_nxt_s = IDLE_HIGH;
        end
      end
      WAIT_LOW: begin
        if (sync_r) begin
          state_nxt_s = IDLE_HIGH;
        end else if (cnt_last_s) begin
          state_nxt_s = IDLE_LOW;
          cnt_nxt_s   = cnt_r + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
        end else begin
          cnt_nxt_s   = cnt_r + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
        end
      end
      default: begin
        state_nxt_s = IDLE_LOW;
        cnt_nxt_s   = {CNT_WIDTH{1'b0}};
      end
    endcase
  end

  // Output decode: strobes fire on the accepting transition, level follows the next state.
  always_comb begin
    press_nxt_s = 1'b0;
    rel_nxt_s   = 1'b0;
    level_nxt_s = (state_nxt_s == IDLE_HIGH) || (state_nxt_s == WAIT_LOW);
    case (state_r)
      WAIT_HIGH: begin
        if (sync_r && cnt_last_s) begin
          press_nxt_s = 1'b1;
        end else begin
          press_nxt_s = 1'b0;
        end
      end
      WAIT_LOW: begin
        if (!sync_r && cnt_last_s) begin
          rel_nxt_s = 1'b1;
        end else begin
          rel_nxt_s = 1'b0;
        end
      end
`ifdef BTN_AUTOREPEAT_EN
      IDLE_HIGH: begin
        press_nxt_s = rep_fire_s;
      end
`endif
      default: begin
        press_nxt_s = 1'b0;
        rel_nxt_s   = 1'b0;
      end
    endcase
  end

  assign level = level_r;
  assign press = press_r;
  assign rel   = rel_r;

endmodule

// File: rtl/input_conditioner.sv
// Board input front-end: synchronizes and debounces switches (shared counter)
// and buttons (per-bit FSM). Optional feature macro: BTN_AUTOREPEAT_EN.
module input_conditioner
  import input_cond_pkg::*;
#(
  parameter int SW_WIDTH        = 16,
  parameter int BTN_COUNT       = 3,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int CNT_WIDTH       = CNT_WIDTH_DEF
`ifdef BTN_AUTOREPEAT_EN
  ,
  parameter int REPEAT_DELAY    = 50000000,
  parameter int REPEAT_PERIOD   = 10000000
`endif
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [SW_WIDTH-1:0]  sw_raw,
  input  logic [BTN_COUNT-1:0] btn_raw,
  output logic [SW_WIDTH-1:0]  sw_out,
  output logic                 sw_changed,
  output logic [BTN_COUNT-1:0] btn_level,
  output logic [BTN_COUNT-1:0] btn_press,
  output logic [BTN_COUNT-1:0] btn_release
);

  logic [SW_WIDTH-1:0]  sw_meta_r;
  logic [SW_WIDTH-1:0]  sw_sync_r;
  logic [SW_WIDTH-1:0]  sw_prev_r;
  logic [SW_WIDTH-1:0]  sw_out_r;
  logic                 sw_changed_r;
  logic [CNT_WIDTH-1:0] sw_cnt_r;
  logic [CNT_WIDTH-1:0] sw_cnt_nxt_s;
  logic                 sw_load_s;
  logic                 sw_cnt_last_s;

  assign sw_cnt_last_s = (sw_cnt_r == CNT_WIDTH'(DEBOUNCE_CYCLES - 2));

  // Shared switch counter: any movement restarts it, so a multi-switch change lands as one update.
  always_comb begin
    sw_cnt_nxt_s = sw_cnt_r;
    sw_load_s    = 1'b0;
    if (sw_sync_r == sw_out_r) begin
      sw_cnt_nxt_s = {CNT_WIDTH{1'b0}};
    end else if (sw_sync_r != sw_prev_r) begin
      sw_cnt_nxt_s = {CNT_WIDTH{1'b0}};
    end else if (sw_cnt_last_s) begin
      sw_load_s    = 1'b1;
      sw_cnt_nxt_s = {CNT_WIDTH{1'b0}};
    end else begin
      sw_cnt_nxt_s = sw_cnt_r + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
    end
  end

  // Switch synchronizer, last-sample tracker, counter and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sw_meta_r    <= {SW_WIDTH{1'b0}};
      sw_sync_r    <= {SW_WIDTH{1'b0}};
      sw_prev_r    <= {SW_WIDTH{1'b0}};
      sw_out_r     <= {SW_WIDTH{1'b0}};
      sw_changed_r <= 1'b0;
      sw_cnt_r     <= {CNT_WIDTH{1'b0}};
    end else begin
      sw_meta_r    <= sw_raw;
      sw_sync_r    <= sw_meta_r;
      sw_prev_r    <= sw_sync_r;
      sw_out_r     <= sw_load_s ? sw_sync_r : sw_out_r;
      sw_changed_r <= sw_load_s;
      sw_cnt_r     <= sw_cnt_nxt_s;
    end
  end

  assign sw_out     = sw_out_r;
  assign sw_changed = sw_changed_r;

  for (genvar i = 0; i < BTN_COUNT; i++) begin : g_btn
    debounce_fsm #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .CNT_WIDTH       (CNT_WIDTH)
`ifdef BTN_AUTOREPEAT_EN
      ,
      .REPEAT_DELAY    (REPEAT_DELAY),
      .REPEAT_PERIOD   (REPEAT_PERIOD)
`endif
    ) u_debounce (
      .clk   (clk),
      .rst   (rst),
      .raw   (btn_raw[i]),
      .level (btn_level[i]),
      .press (btn_press[i]),
      .rel   (btn_release[i])
    );
  end

endmodule

// File: tb/tb_input_conditioner.sv
// Directed, table-driven bench for input_conditioner with DEBOUNCE_CYCLES=4.
module tb_input_conditioner;

  logic        clk;
  logic        rst;
  logic [15:0] sw_raw;
  logic [2:0]  btn_raw;
  logic [15:0] sw_out;
  logic        sw_changed;
  logic [2:0]  btn_level;
  logic [2:0]  btn_press;
  logic [2:0]  btn_release;

  int n_checks;
  int n_fail;

  input_conditioner #(
    .SW_WIDTH        (16),
    .BTN_COUNT       (3),
    .DEBOUNCE_CYCLES (4),
    .CNT_WIDTH       (3)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .sw_raw      (sw_raw),
    .btn_raw     (btn_raw),
    .sw_out      (sw_out),
    .sw_changed  (sw_changed),
    .btn_level   (btn_level),
    .btn_press   (btn_press),
    .btn_release (btn_release)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] sw;
    logic [2:0]  btn;
    logic [15:0] e_sw;
    logic        e_chg;
    logic [2:0]  e_lvl;
    logic [2:0]  e_press;
    logic [2:0]  e_rel;
  } vec_t;

  vec_t tbl [19];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  function automatic vec_t mk(input logic [15:0] sw, input logic [2:0] btn, input logic [15:0] e_sw,
                              input logic e_chg, input logic [2:0] e_lvl, input logic [2:0] e_press);
    vec_t v;
    v.sw = sw; v.btn = btn; v.e_sw = e_sw; v.e_chg = e_chg;
    v.e_lvl = e_lvl; v.e_press = e_press; v.e_rel = 3'b000;
    return v;
  endfunction

  initial begin
    n_checks = 0;
    n_fail   = 0;
    // Entry i holds inputs driven before edge i+1 and outputs expected after it.
    for (int i = 0; i < 5; i++) tbl[i] = mk(16'hA5C3, 3'b001, 16'h0000, 1'b0, 3'b000, 3'b000);
    tbl[5] = mk(16'hA5C3, 3'b001, 16'hA5C3, 1'b1, 3'b001, 3'b001);
    for (int i = 6; i < 9; i++) tbl[i] = mk(16'hA5C3, 3'b001, 16'hA5C3, 1'b0, 3'b001, 3'b000);
    tbl[9]  = mk(16'h1234, 3'b001, 16'hA5C3, 1'b0, 3'b001, 3'b000);
    tbl[10] = mk(16'h1234, 3'b001, 16'hA5C3, 1'b0, 3'b001, 3'b000);
    for (int i = 11; i < 16; i++) tbl[i] = mk(16'h1235, 3'b001, 16'hA5C3, 1'b0, 3'b001, 3'b000);
    tbl[16] = mk(16'h1235, 3'b001, 16'h1235, 1'b1, 3'b001, 3'b000);
    for (int i = 17; i < 19; i++) tbl[i] = mk(16'h1235, 3'b001, 16'h1235, 1'b0, 3'b001, 3'b000);

    rst = 1'b1; sw_raw = 16'h0000; btn_raw = 3'b000;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_sw_out", {16'h0000, sw_out}, 32'h0);
    check("reset_btn", {26'd0, btn_level, btn_press}, 32'h0);
    check("reset_strobes", {28'd0, sw_changed, btn_release}, 32'h0);
    rst = 1'b0;

    for (int i = 0; i < 19; i++) begin
      sw_raw = tbl[i].sw; btn_raw = tbl[i].btn;
      step();
      check($sformatf("tbl%0d_sw_out", i), {16'h0000, sw_out}, {16'h0000, tbl[i].e_sw});
      check($sformatf("tbl%0d_sw_changed", i), {31'd0, sw_changed}, {31'd0, tbl[i].e_chg});
      check($sformatf("tbl%0d_btn_level", i), {29'd0, btn_level}, {29'd0, tbl[i].e_lvl});
      check($sformatf("tbl%0d_btn_press", i), {29'd0, btn_press}, {29'd0, tbl[i].e_press});
      check($sformatf("tbl%0d_btn_release", i), {29'd0, btn_release}, {29'd0, tbl[i].e_rel});
    end

    // Bouncing button 1 must never be accepted.
    for (int i = 0; i < 30; i++) begin
      btn_raw[1] = (i < 20) ? ((i % 2) == 0) : 1'b0;
      step();
      check($sformatf("bounce%0d_btn1", i), {29'd0, btn_press[1], btn_release[1], btn_level[1]}, 32'h0);
    end

    // Button 2 press then release, each accepted exactly 6 cycles after the pin edge.
    btn_raw[2] = 1'b1;
    for (int k = 1; k <= 7; k++) begin
      step();
      check($sformatf("press2_c%0d", k), {30'd0, btn_press[2], btn_level[2]},
            (k == 6) ? 32'h3 : ((k == 7) ? 32'h1 : 32'h0));
    end
    btn_raw[2] = 1'b0;
    for (int k = 1; k <= 7; k++) begin
      step();
      check($sformatf("release2_c%0d", k), {29'd0, btn_release[2], btn_press[2], btn_level[2]},
            (k == 6) ? 32'h4 : ((k == 7) ? 32'h0 : 32'h1));
    end

    // Reset in the middle of button 1 debounce; buttons 0 and 1 are held through it.
    btn_raw[1] = 1'b1;
    repeat (4) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("midrst_sw_out", {16'h0000, sw_out}, 32'h0);
    check("midrst_btn", {26'd0, btn_level, btn_press}, 32'h0);
    check("midrst_strobes", {28'd0, sw_changed, btn_release}, 32'h0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int k = 1; k <= 7; k++) begin
      step();
      check($sformatf("postrst_press_c%0d", k), {29'd0, btn_press}, (k == 6) ? 32'h3 : 32'h0);
      check($sformatf("postrst_level_c%0d", k), {29'd0, btn_level}, (k >= 6) ? 32'h3 : 32'h0);
      check($sformatf("postrst_sw_c%0d", k), {15'd0, sw_changed, sw_out},
            (k == 6) ? 32'h0001_1235 : ((k == 7) ? 32'h0000_1235 : 32'h0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
